// File: rtl/tmds_decoder_pkg.sv
// Shared TMDS/TERC4 constants, FSM state encoding and small decode helpers
// for the HDMI receive-side channel decoder.
package tmds_decoder_pkg;

   // Control-period tokens, named by the {c1,c0} value they carry
   localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

   // Guard-band codes: channels 0/2 use GB_VID_CH02 for video guards;
   // GB_ALT is the channel-1 video guard and the channel-1/2 island guard
   localparam logic [9:0] GB_VID_CH02 = 10'b1011001100;
   localparam logic [9:0] GB_ALT      = 10'b0100110011;

   // TERC4 transmit table, entry n is the symbol sent for nibble n
   localparam logic [15:0][9:0] TERC4_TBL = {
      10'b1011000011,  // F
      10'b0101100011,  // E
      10'b1001110001,  // D
      10'b1010001110,  // C
      10'b1011000110,  // B
      10'b0110011100,  // A
      10'b0100111001,  // 9
      10'b1011001100,  // 8
      10'b0100111100,  // 7
      10'b0110001110,  // 6
      10'b0100011110,  // 5
      10'b0101110001,  // 4
      10'b1011100010,  // 3
      10'b1011100100,  // 2
      10'b1001100011,  // 1
      10'b1010011100   // 0
   };

   typedef enum logic [2:0] {
      ST_CTRL     = 3'd0,
      ST_VID_GB   = 3'd1,
      ST_VIDEO    = 3'd2,
      ST_DI_LEAD  = 3'd3,
      ST_ISLAND   = 3'd4,
      ST_DI_TRAIL = 3'd5
   } state_t;

   // Returns {hit, c1, c0}; hit=0 for anything that is not a control token
   function automatic logic [2:0] ctrl_decode(input logic [9:0] sym);
      logic [2:0] res;
      case (sym)
         CTRL_TOK_00: res = 3'b100;
         CTRL_TOK_01: res = 3'b101;
         CTRL_TOK_10: res = 3'b110;
         CTRL_TOK_11: res = 3'b111;
         default:     res = 3'b000;
      endcase
      return res;
   endfunction

   // TMDS video decode: undo optional inversion, then undo XOR/XNOR chain
   function automatic logic [7:0] video_decode(input logic [9:0] sym);
      logic [7:0] d;
      logic [7:0] p;
      d    = sym[9] ? ~sym[7:0] : sym[7:0];
      p[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         p[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return p;
   endfunction

endpackage

// File: rtl/tmds_decoder_terc4.sv
// Combinational TERC4 lookup: 10-bit symbol -> {valid, nibble}.
// valid is low for any symbol that is not one of the 16 table entries.
module terc4_decode
   import tmds_decoder_pkg::*;
(
   input  logic [9:0] i_symbol,
   output logic       o_valid,
   output logic [3:0] o_nibble
);

   // Linear search of the 16-entry table; at most one entry can match
   always_comb begin
      o_valid  = 1'b0;
      o_nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (i_symbol == TERC4_TBL[i]) begin
            o_valid  = 1'b1;
            o_nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/tmds_decoder.sv
// HDMI RX TMDS channel decoder. Stage 1 registers the aligned symbol,
// stage 2 classifies it against the current HDMI period and registers the
// decoded outputs. One instance per channel; CHANNEL selects guard rules.
module tmds_decoder
   import tmds_decoder_pkg::*;
#(
   parameter int CHANNEL = 0,
   parameter int ERR_W   = 16
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [9:0]       i_tmds_symbol,
   input  logic             i_island_hint,
   output logic [7:0]       o_pixel_component,
   output logic [3:0]       o_aux_data,
   output logic             o_c0,
   output logic             o_c1,
   output logic             o_vde,
   output logic             o_ade,
   output logic             o_di_gb_det,
   output logic             o_symbol_err,
   output logic [ERR_W-1:0] o_err_count
);

   // Stage-1 symbol and a valid flag so the reset value of the symbol
   // register is never classified as a (bogus) received symbol
   logic [9:0]       r_sym;
   logic             r_s1_vld;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_gb_cnt;
   logic             w_gb_cnt_nxt;

   logic             r_vde, r_ade, r_err;
   logic [7:0]       r_pix;
   logic [3:0]       r_aux;
   logic [1:0]       r_c;
   logic [ERR_W-1:0] r_err_cnt;

   logic             w_vde_nxt, w_ade_nxt, w_err_nxt;
   logic [7:0]       w_pix_nxt;
   logic [3:0]       w_aux_nxt;
   logic [1:0]       w_c_nxt;

   // Stage-2 classification of the stage-1 symbol
   logic [2:0]       w_ctrl;
   logic             w_ctrl_hit;
   logic [1:0]       w_ctrl_c;
   logic             w_terc_vld;
   logic [3:0]       w_terc_nib;
   logic [7:0]       w_pix_dec;
   logic             w_vid_gb;
   logic             w_isl_gb;
   logic             w_ctrl_vid_gb;
   logic             w_ctrl_isl_gb;

   assign w_ctrl     = ctrl_decode(r_sym);
   assign w_ctrl_hit = w_ctrl[2];
   assign w_ctrl_c   = w_ctrl[1:0];
   assign w_pix_dec  = video_decode(r_sym);

   terc4_decode u_terc4 (
      .i_symbol (r_sym),
      .o_valid  (w_terc_vld),
      .o_nibble (w_terc_nib)
   );

   // Channel 0 has no dedicated island guard code: its guard is any TERC4
   // nibble 11cc, which also carries hsync/vsync in the low bits
   assign w_vid_gb = (CHANNEL == 1) ? (r_sym == GB_ALT) : (r_sym == GB_VID_CH02);
   assign w_isl_gb = (CHANNEL == 0) ? (w_terc_vld && (w_terc_nib[3:2] == 2'b11))
                                    : (r_sym == GB_ALT);

   // Channel 1 uses one code for both guards; channel 2's guard detection
   // (island_hint) tells which period is starting
   assign w_ctrl_vid_gb = w_vid_gb && !((CHANNEL == 1) && i_island_hint);
   assign w_ctrl_isl_gb = w_isl_gb && ((CHANNEL != 1) || i_island_hint);

   // Stage 1: capture the incoming symbol
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sym    <= '0;
         r_s1_vld <= 1'b0;
      end else begin
         r_sym    <= i_tmds_symbol;
         r_s1_vld <= 1'b1;
      end
   end

   // FSM state register and guard-symbol counter
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= ST_CTRL;
         r_gb_cnt <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_gb_cnt <= w_gb_cnt_nxt;
      end
   end

   // Next-state logic; r_gb_cnt=1 means one guard symbol already seen
   always_comb begin
      w_state_nxt  = r_state;
      w_gb_cnt_nxt = r_gb_cnt;
      if (r_s1_vld) begin
         case (r_state)
            ST_CTRL: begin
               if (!w_ctrl_hit && w_ctrl_vid_gb) begin
                  w_state_nxt  = ST_VID_GB;
                  w_gb_cnt_nxt = 1'b1;
               end else if (!w_ctrl_hit && w_ctrl_isl_gb) begin
                  w_state_nxt  = ST_DI_LEAD;
                  w_gb_cnt_nxt = 1'b1;
               end
            end
            ST_VID_GB: begin
               if (w_vid_gb) begin
                  w_state_nxt  = r_gb_cnt ? ST_VIDEO : ST_VID_GB;
                  w_gb_cnt_nxt = ~r_gb_cnt;
               end else begin
                  w_state_nxt  = ST_CTRL;
                  w_gb_cnt_nxt = 1'b0;
               end
            end
            ST_VIDEO: begin
               if (w_ctrl_hit) w_state_nxt = ST_CTRL;
            end
            ST_DI_LEAD: begin
               if (w_isl_gb) begin
                  w_state_nxt  = r_gb_cnt ? ST_ISLAND : ST_DI_LEAD;
                  w_gb_cnt_nxt = ~r_gb_cnt;
               end else begin
                  w_state_nxt  = ST_CTRL;
                  w_gb_cnt_nxt = 1'b0;
               end
            end
            ST_ISLAND: begin
               if (CHANNEL != 0 && w_isl_gb) begin
                  w_state_nxt  = ST_DI_TRAIL;
                  w_gb_cnt_nxt = 1'b1;
               end else if (w_ctrl_hit) begin
                  w_state_nxt  = ST_CTRL;
               end
            end
            ST_DI_TRAIL: begin
               if (w_isl_gb && !r_gb_cnt) begin
                  w_gb_cnt_nxt = 1'b1;
               end else begin
                  w_state_nxt  = ST_CTRL;
                  w_gb_cnt_nxt = 1'b0;
               end
            end
            default: begin
               w_state_nxt  = ST_CTRL;
               w_gb_cnt_nxt = 1'b0;
            end
         endcase
      end
   end

   // Output decode per period; data outputs hold unless refreshed
   always_comb begin
      w_vde_nxt = 1'b0;
      w_ade_nxt = 1'b0;
      w_err_nxt = 1'b0;
      w_pix_nxt = r_pix;
      w_aux_nxt = r_aux;
      w_c_nxt   = r_c;
      if (r_s1_vld) begin
         case (r_state)
            ST_CTRL: begin
               if (w_ctrl_hit) begin
                  w_c_nxt = w_ctrl_c;
               end else if (w_ctrl_vid_gb) begin
                  w_c_nxt = r_c;
               end else if (w_ctrl_isl_gb) begin
                  if (CHANNEL == 0) w_c_nxt = w_terc_nib[1:0];
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
            ST_VID_GB: begin
               if (!w_vid_gb) w_err_nxt = 1'b1;
            end
            ST_VIDEO: begin
               if (w_ctrl_hit) begin
                  w_c_nxt = w_ctrl_c;
               end else begin
                  w_vde_nxt = 1'b1;
                  w_pix_nxt = w_pix_dec;
               end
            end
            ST_DI_LEAD: begin
               if (!w_isl_gb)          w_err_nxt = 1'b1;
               else if (CHANNEL == 0)  w_c_nxt   = w_terc_nib[1:0];
            end
            ST_ISLAND: begin
               if (CHANNEL != 0 && w_isl_gb) begin
                  w_c_nxt = r_c;
               end else if (w_ctrl_hit) begin
                  // Channels 1/2 must see a trailer guard before control
                  w_c_nxt   = w_ctrl_c;
                  w_err_nxt = (CHANNEL != 0);
               end else if (w_terc_vld) begin
                  w_ade_nxt = 1'b1;
                  w_aux_nxt = w_terc_nib;
                  if (CHANNEL == 0) w_c_nxt = w_terc_nib[1:0];
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
            ST_DI_TRAIL: begin
               if (!w_isl_gb) w_err_nxt = 1'b1;
            end
            default: w_err_nxt = 1'b0;
         endcase
      end
   end

   // Stage 2: register decoded outputs and the saturating error count
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_vde     <= 1'b0;
         r_ade     <= 1'b0;
         r_err     <= 1'b0;
         r_pix     <= '0;
         r_aux     <= '0;
         r_c       <= '0;
         r_err_cnt <= '0;
      end else begin
         r_vde <= w_vde_nxt;
         r_ade <= w_ade_nxt;
         r_err <= w_err_nxt;
         r_pix <= w_pix_nxt;
         r_aux <= w_aux_nxt;
         r_c   <= w_c_nxt;
         if (w_err_nxt && (r_err_cnt != {ERR_W{1'b1}}))
            r_err_cnt <= r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_pixel_component = r_pix;
   assign o_aux_data        = r_aux;
   assign o_c0              = r_c[0];
   assign o_c1              = r_c[1];
   assign o_vde             = r_vde;
   assign o_ade             = r_ade;
   assign o_symbol_err      = r_err;
   assign o_err_count       = r_err_cnt;
   assign o_di_gb_det       = (r_sym == GB_ALT);

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: channel 0/1/2 instances plus a narrow
// error-counter channel-0 instance for saturation.
module tb_tmds_decoder;

   typedef struct packed {
      logic       vde;
      logic       ade;
      logic       c1;
      logic       c0;
      logic       err;
      logic [7:0] pix;
      logic [3:0] aux;
   } exp_t;

   localparam logic [9:0] C00  = 10'b1101010100;
   localparam logic [9:0] C01  = 10'b0010101011;
   localparam logic [9:0] C11  = 10'b1010101011;
   localparam logic [9:0] VGB0 = 10'b1011001100;
   localparam logic [9:0] IGB  = 10'b0100110011;
   localparam logic [9:0] T0   = 10'b1010011100;
   localparam logic [9:0] TF   = 10'b1011000011;
   localparam logic [9:0] TD   = 10'b1001110001;
   localparam logic [9:0] P00  = 10'b0100000000;
   localparam logic [9:0] PFF  = 10'b1000000000;
   localparam logic [9:0] BAD  = 10'b1111111111;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] s0 = C00, s1 = C00, s2 = C00;
   int         sel = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   exp_t       sb[$];

   logic [7:0]  pix0, pix1, pix2, pix3;
   logic [3:0]  aux0, aux1, aux2, aux3;
   logic        c00, c01, c02, c03, c10, c11, c12, c13;
   logic        vde0, vde1, vde2, vde3, ade0, ade1, ade2, ade3;
   logic        gb0, gb1, gb2, gb3, er0, er1, er2, er3;
   logic [15:0] ec0, ec1, ec2;
   logic [2:0]  ec3;
   exp_t        obs0, obs1, obs2, obs3, cur;

   always #5 clk = ~clk;

   tmds_decoder #(.CHANNEL(0), .ERR_W(16)) u0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_tmds_symbol(s0), .i_island_hint(1'b0),
      .o_pixel_component(pix0), .o_aux_data(aux0), .o_c0(c00), .o_c1(c10),
      .o_vde(vde0), .o_ade(ade0), .o_di_gb_det(gb0), .o_symbol_err(er0), .o_err_count(ec0));
   tmds_decoder #(.CHANNEL(1), .ERR_W(16)) u1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_tmds_symbol(s1), .i_island_hint(gb2),
      .o_pixel_component(pix1), .o_aux_data(aux1), .o_c0(c01), .o_c1(c11),
      .o_vde(vde1), .o_ade(ade1), .o_di_gb_det(gb1), .o_symbol_err(er1), .o_err_count(ec1));
   tmds_decoder #(.CHANNEL(2), .ERR_W(16)) u2 (
      .i_clk(clk), .i_reset_n(rst_n), .i_tmds_symbol(s2), .i_island_hint(1'b0),
      .o_pixel_component(pix2), .o_aux_data(aux2), .o_c0(c02), .o_c1(c12),
      .o_vde(vde2), .o_ade(ade2), .o_di_gb_det(gb2), .o_symbol_err(er2), .o_err_count(ec2));
   tmds_decoder #(.CHANNEL(0), .ERR_W(3)) u3 (
      .i_clk(clk), .i_reset_n(rst_n), .i_tmds_symbol(s0), .i_island_hint(1'b0),
      .o_pixel_component(pix3), .o_aux_data(aux3), .o_c0(c03), .o_c1(c13),
      .o_vde(vde3), .o_ade(ade3), .o_di_gb_det(gb3), .o_symbol_err(er3), .o_err_count(ec3));

   assign obs0 = {vde0, ade0, c10, c00, er0, pix0, aux0};
   assign obs1 = {vde1, ade1, c11, c01, er1, pix1, aux1};
   assign obs2 = {vde2, ade2, c12, c02, er2, pix2, aux2};
   assign obs3 = {vde3, ade3, c13, c03, er3, pix3, aux3};

   always_comb begin
      cur = obs0;
      case (sel)
         1: cur = obs1;
         2: cur = obs2;
         3: cur = obs3;
         default: cur = obs0;
      endcase
   end

   function automatic exp_t mk(logic vde, logic ade, logic c1, logic c0, logic err,
                               logic [7:0] pix, logic [3:0] aux);
      mk = {vde, ade, c1, c0, err, pix, aux};
   endfunction

   // Drive one symbol (b goes to channel 2) across one rising edge
   task automatic step(input logic [9:0] a, input logic [9:0] b);
      s0 = a; s1 = a; s2 = b;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      s0 = C00; s1 = C00; s2 = C00;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic test_reset();
      exp_t e;
      sel = 0;
      do_reset();
      n_chk++;
      if (cur !== '0) begin n_fail++; $display("FAIL reset_outs got %h exp 0", cur); end
      n_chk++;
      if (ec0 !== 16'd0) begin n_fail++; $display("FAIL reset_errcnt got %h exp 0", ec0); end
      step(C00, C00); step(VGB0, VGB0); step(VGB0, VGB0); step(P00, P00); step(PFF, PFF);
      n_chk++;
      if (vde0 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_vde got %b exp 1", vde0); end
      s0 = C00; s1 = C00; s2 = C00;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (cur !== '0) begin n_fail++; $display("FAIL async_reset got %h exp 0", cur); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back(mk(0, 0, 0, 1, 0, 8'h00, 4'h0));
      step(C01, C01);
      n_chk++;
      if (cur !== '0) begin n_fail++; $display("FAIL post_reset_1clk got %h exp 0", cur); end
      step(C00, C00);
      e = sb.pop_front();
      n_chk++;
      if (cur !== e) begin n_fail++; $display("FAIL post_reset_c0 got %h exp %h", cur, e); end
   endtask

   task automatic test_video();
      logic [9:0] syms [9];
      exp_t       exps [9];
      exp_t       e;
      sel = 0;
      do_reset();
      syms = '{C00, C00, C00, C00, VGB0, VGB0, P00, PFF, C11};
      exps = '{mk(0,0,0,0,0,8'h00,4'h0), mk(0,0,0,0,0,8'h00,4'h0), mk(0,0,0,0,0,8'h00,4'h0),
               mk(0,0,0,0,0,8'h00,4'h0), mk(0,0,0,0,0,8'h00,4'h0), mk(0,0,0,0,0,8'h00,4'h0),
               mk(1,0,0,0,0,8'h00,4'h0), mk(1,0,0,0,0,8'hFF,4'h0), mk(0,0,1,1,0,8'hFF,4'h0)};
      for (int i = 0; i <= 9; i++) begin
         if (i < 9) sb.push_back(exps[i]);
         step(i < 9 ? syms[i] : C00, i < 9 ? syms[i] : C00);
         if (i > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (cur !== e) begin n_fail++; $display("FAIL test_video[%0d] got %h exp %h", i-1, cur, e); end
         end
      end
   endtask

   task automatic test_island_ch2();
      logic [9:0] syms [7];
      exp_t       exps [7];
      exp_t       e;
      sel = 2;
      do_reset();
      syms = '{IGB, IGB, T0, TF, IGB, IGB, C00};
      exps = '{mk(0,0,0,0,0,8'h00,4'h0), mk(0,0,0,0,0,8'h00,4'h0), mk(0,1,0,0,0,8'h00,4'h0),
               mk(0,1,0,0,0,8'h00,4'hF), mk(0,0,0,0,0,8'h00,4'hF), mk(0,0,0,0,0,8'h00,4'hF),
               mk(0,0,0,0,0,8'h00,4'hF)};
      for (int i = 0; i <= 7; i++) begin
         if (i < 7) sb.push_back(exps[i]);
         step(i < 7 ? syms[i] : C00, i < 7 ? syms[i] : C00);
         if (i == 0) begin
            n_chk++;
            if (gb2 !== 1'b1) begin n_fail++; $display("FAIL ch2_gb_det got %b exp 1", gb2); end
         end
         if (i > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (cur !== e) begin n_fail++; $display("FAIL test_island_ch2[%0d] got %h exp %h", i-1, cur, e); end
         end
      end
      n_chk++;
      if (ec2 !== 16'd0) begin n_fail++; $display("FAIL ch2_errcnt got %0d exp 0", ec2); end
   endtask

   task automatic test_ch1_hint();
      logic [9:0] sa [6];
      exp_t       ea [6];
      logic [9:0] sv [4];
      exp_t       ev [4];
      exp_t       e;
      sel = 1;
      do_reset();
      // channel 2 sees the same guards, so the hint is high: island path
      sa = '{IGB, IGB, TF, IGB, IGB, C00};
      ea = '{mk(0,0,0,0,0,8'h00,4'h0), mk(0,0,0,0,0,8'h00,4'h0), mk(0,1,0,0,0,8'h00,4'hF),
             mk(0,0,0,0,0,8'h00,4'hF), mk(0,0,0,0,0,8'h00,4'hF), mk(0,0,0,0,0,8'h00,4'hF)};
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) sb.push_back(ea[i]);
         step(i < 6 ? sa[i] : C00, i < 6 ? sa[i] : C00);
         if (i > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (cur !== e) begin n_fail++; $display("FAIL ch1_hint1[%0d] got %h exp %h", i-1, cur, e); end
         end
      end
      do_reset();
      // channel 2 stays in control, hint low: video path
      sv = '{IGB, IGB, PFF, C01};
      ev = '{mk(0,0,0,0,0,8'h00,4'h0), mk(0,0,0,0,0,8'h00,4'h0), mk(1,0,0,0,0,8'hFF,4'h0),
             mk(0,0,0,1,0,8'hFF,4'h0)};
      for (int i = 0; i <= 4; i++) begin
         if (i < 4) sb.push_back(ev[i]);
         step(i < 4 ? sv[i] : C00, C00);
         if (i > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (cur !== e) begin n_fail++; $display("FAIL ch1_hint0[%0d] got %h exp %h", i-1, cur, e); end
         end
      end
   endtask

   task automatic test_island_ch0();
      logic [9:0] syms [6];
      exp_t       exps [6];
      exp_t       e;
      sel = 0;
      do_reset();
      syms = '{TD, TD, T0, TD, TD, C00};
      exps = '{mk(0,0,0,1,0,8'h00,4'h0), mk(0,0,0,1,0,8'h00,4'h0), mk(0,1,0,0,0,8'h00,4'h0),
               mk(0,1,0,1,0,8'h00,4'hD), mk(0,1,0,1,0,8'h00,4'hD), mk(0,0,0,0,0,8'h00,4'hD)};
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) sb.push_back(exps[i]);
         step(i < 6 ? syms[i] : C00, i < 6 ? syms[i] : C00);
         if (i > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (cur !== e) begin n_fail++; $display("FAIL test_island_ch0[%0d] got %h exp %h", i-1, cur, e); end
         end
      end
      n_chk++;
      if (ec0 !== 16'd0) begin n_fail++; $display("FAIL ch0_island_errcnt got %0d exp 0", ec0); end
   endtask

   task automatic test_errors();
      logic [9:0] syms [6];
      exp_t       exps [6];
      exp_t       e;
      sel = 0;
      do_reset();
      syms = '{BAD, C00, TD, TD, BAD, C00};
      exps = '{mk(0,0,0,0,1,8'h00,4'h0), mk(0,0,0,0,0,8'h00,4'h0), mk(0,0,0,1,0,8'h00,4'h0),
               mk(0,0,0,1,0,8'h00,4'h0), mk(0,0,0,1,1,8'h00,4'h0), mk(0,0,0,0,0,8'h00,4'h0)};
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) sb.push_back(exps[i]);
         step(i < 6 ? syms[i] : C00, i < 6 ? syms[i] : C00);
         if (i > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (cur !== e) begin n_fail++; $display("FAIL test_errors[%0d] got %h exp %h", i-1, cur, e); end
         end
      end
      n_chk++;
      if (ec0 !== 16'd2) begin n_fail++; $display("FAIL errcnt_two got %0d exp 2", ec0); end
      n_chk++;
      if (ec3 !== 3'd2) begin n_fail++; $display("FAIL errcnt_narrow_two got %0d exp 2", ec3); end
      for (int i = 0; i < 10; i++) step(BAD, BAD);
      step(C00, C00);
      n_chk++;
      if (ec0 !== 16'd12) begin n_fail++; $display("FAIL errcnt_twelve got %0d exp 12", ec0); end
      n_chk++;
      if (ec3 !== 3'd7) begin n_fail++; $display("FAIL errcnt_saturate got %0d exp 7", ec3); end
      step(BAD, BAD);
      step(C00, C00);
      n_chk++;
      if (ec3 !== 3'd7) begin n_fail++; $display("FAIL errcnt_no_wrap got %0d exp 7", ec3); end
      n_chk++;
      if (ec0 !== 16'd13) begin n_fail++; $display("FAIL errcnt_thirteen got %0d exp 13", ec0); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_video();
      test_island_ch2();
      test_ch1_hint();
      test_island_ch0();
      test_errors();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
